phy_rx_link_ctrl: RTL and testbench

Link-bring-up controller for the two-lane receive PHY. It watches the byte stream and valid flag of each serial-to-parallel lane, detects per-lane alignment on the comma symbol, and only then enables the byte un-striper and the downstream demux. If symbol errors persist it drops the link and re-runs alignment. It sits beside the receive datapath in the `clk_2f` domain, between the two serial-to-parallel converters and the un-striping stage.

---
 rtl/phy_rx_pkg.sv | 44 ++++
 rtl/phy_rx_lane_lock.sv | 94 +++++++++
 rtl/phy_rx_link_ctrl.sv | 164 ++++++++++++++++
 tb/tb_phy_rx_link_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_rx_pkg.sv
// -----------------------------------------------------------------------------
// phy_rx_pkg
// Shared definitions for the two-lane receive PHY link-bring-up controller.
//   - Link FSM state encoding (ST_IDLE / ST_ALIGN / ST_ACTIVE), 2-bit constants
//     so they can be driven straight onto the `state` output port.
//   - Default comma/idle symbol.
//   - Counter widths: 4-bit lock/loss/resync counters, 8-bit ALIGN timer.
//   - Strobed-byte classification and a saturating increment helper.
// -----------------------------------------------------------------------------
package phy_rx_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ALIGN  = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;

   localparam logic [7:0] COM_SYM_DEF = 8'hBC;

   localparam int CNT_W = 4;
   localparam int TMR_W = 8;

   typedef enum logic [1:0] {
      SYM_NONE  = 2'd0,   // no strobe this cycle
      SYM_COMMA = 2'd1,   // strobed, not valid, equals the comma symbol
      SYM_DATA  = 2'd2,   // strobed and valid
      SYM_BAD   = 2'd3    // strobed, not valid, anything but the comma
   } sym_kind_e;

   function automatic sym_kind_e classify(input logic       stb,
                                          input logic       valid,
                                          input logic [7:0] lane_byte,
                                          input logic [7:0] com_sym);
      sym_kind_e k;
      if (!stb)                      k = SYM_NONE;
      else if (valid)                k = SYM_DATA;
      else if (lane_byte == com_sym) k = SYM_COMMA;
      else                           k = SYM_BAD;
      return k;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/phy_rx_lane_lock.sv
// -----------------------------------------------------------------------------
// phy_rx_lane_lock
// Per-lane comma lock tracker and symbol-loss tracker.
//   clk_2f       in   block clock, rising edge
//   reset        in   synchronous, active-low
//   lane_byte    in   8-bit byte from the serial-to-parallel converter
//   valid        in   byte carries data (high) or a control symbol (low)
//   stb          in   one-cycle pulse: lane_byte/valid hold a new byte
//   align_mode   in   link FSM is in ALIGN: run the comma lock tracker
//   active_mode  in   link FSM is in ACTIVE: run the bad-symbol tracker
//   clear        in   drop lock and zero both counters on this edge
//   lock         out  lane has seen LOCK_CNT consecutive commas (registered)
//   loss         out  LOSS_CNT consecutive bad bytes seen in ACTIVE
// -----------------------------------------------------------------------------
module phy_rx_lane_lock
   import phy_rx_pkg::*;
#(
   parameter logic [7:0] COM_SYM  = COM_SYM_DEF,
   parameter int         LOCK_CNT = 4,
   parameter int         LOSS_CNT = 2
) (
   input  logic       clk_2f,
   input  logic       reset,
   input  logic [7:0] lane_byte,
   input  logic       valid,
   input  logic       stb,
   input  logic       align_mode,
   input  logic       active_mode,
   input  logic       clear,
   output logic       lock,
   output logic       loss
);

   localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0] LOSS_MAX = CNT_W'(LOSS_CNT);

   sym_kind_e        kind;
   logic [CNT_W-1:0] com_cnt_d, com_cnt_q;
   logic [CNT_W-1:0] bad_cnt_d, bad_cnt_q;
   logic             lock_d,    lock_q;

   always_comb begin
      kind      = classify(stb, valid, lane_byte, COM_SYM);
      com_cnt_d = com_cnt_q;
      bad_cnt_d = bad_cnt_q;
      lock_d    = lock_q;

      if (clear) begin
         com_cnt_d = '0;
         bad_cnt_d = '0;
         lock_d    = 1'b0;
      end else begin
         if (align_mode) begin
            if (kind == SYM_COMMA) begin
               if (com_cnt_q != LOCK_MAX) begin
                  com_cnt_d = com_cnt_q + 1'b1;
               end
               // Lock is taken on the same edge the run reaches LOCK_CNT,
               // so lock_q rises right after the LOCK_CNT-th comma.
               if (com_cnt_q == LOCK_MAX - 1'b1) begin
                  lock_d = 1'b1;
               end
            end else if ((kind != SYM_NONE) && !lock_q) begin
               // Once locked, stray symbols no longer break the run.
               com_cnt_d = '0;
            end
         end

         if (active_mode) begin
            if (kind == SYM_BAD) begin
               bad_cnt_d = sat_inc(bad_cnt_q);
            end else if (kind != SYM_NONE) begin
               bad_cnt_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk_2f) begin
      if (!reset) begin
         com_cnt_q <= '0;
         bad_cnt_q <= '0;
         lock_q    <= 1'b0;
      end else begin
         com_cnt_q <= com_cnt_d;
         bad_cnt_q <= bad_cnt_d;
         lock_q    <= lock_d;
      end
   end

   assign lock = lock_q;
   assign loss = (bad_cnt_q >= LOSS_MAX);

endmodule

// File: rtl/phy_rx_link_ctrl.sv
// -----------------------------------------------------------------------------
// phy_rx_link_ctrl
// Link-bring-up controller for the two-lane receive PHY. Aligns both lanes on
// the comma symbol, enables the un-striper once both are locked, and drops
// back to ALIGN when one lane produces LOSS_CNT consecutive bad symbols.
//   clk_2f         in   block clock, rising edge
//   reset          in   synchronous, active-low
//   enable         in   link enable; low forces IDLE (highest priority)
//   lane_0/1       in   8-bit lane bytes
//   valid_0/1      in   lane valid flags
//   stb_0/1        in   one-cycle new-byte strobes
//   state          out  0 IDLE, 1 ALIGN, 2 ACTIVE
//   lock_0/1       out  lane-locked flags
//   unstripe_en    out  high exactly while state is ACTIVE
//   align_timeout  out  one-cycle pulse when an ALIGN window expires
//   resync_cnt     out  ACTIVE->ALIGN drop count, saturates at 15
// -----------------------------------------------------------------------------
module phy_rx_link_ctrl
   import phy_rx_pkg::*;
#(
   parameter logic [7:0] COM_SYM  = COM_SYM_DEF,
   parameter int         LOCK_CNT = 4,
   parameter int         LOSS_CNT = 2,
   parameter int         TIMEOUT  = 64
) (
   input  logic             clk_2f,
   input  logic             reset,
   input  logic             enable,
   input  logic [7:0]       lane_0,
   input  logic             valid_0,
   input  logic             stb_0,
   input  logic [7:0]       lane_1,
   input  logic             valid_1,
   input  logic             stb_1,
   output logic [1:0]       state,
   output logic             lock_0,
   output logic             lock_1,
   output logic             unstripe_en,
   output logic             align_timeout,
   output logic [CNT_W-1:0] resync_cnt
);

   // The timeout fires on the edge where the timer would step to TIMEOUT-1,
   // so the pulse is visible in the (TIMEOUT-1)-th cycle after entering ALIGN.
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 2);

   logic [1:0]       state_d,    state_q;
   logic [TMR_W-1:0] tmr_d,      tmr_q;
   logic             to_d,       to_q;
   logic             unstr_d,    unstr_q;
   logic [CNT_W-1:0] resync_d,   resync_q;

   logic             align_mode;
   logic             active_mode;
   logic             lane_clear;
   logic             lock_0_w, lock_1_w;
   logic             loss_0_w, loss_1_w;

   assign align_mode  = (state_q == ST_ALIGN);
   assign active_mode = (state_q == ST_ACTIVE);

   phy_rx_lane_lock #(
      .COM_SYM  (COM_SYM),
      .LOCK_CNT (LOCK_CNT),
      .LOSS_CNT (LOSS_CNT)
   ) u_lane_0 (
      .clk_2f      (clk_2f),
      .reset       (reset),
      .lane_byte   (lane_0),
      .valid       (valid_0),
      .stb         (stb_0),
      .align_mode  (align_mode),
      .active_mode (active_mode),
      .clear       (lane_clear),
      .lock        (lock_0_w),
      .loss        (loss_0_w)
   );

   phy_rx_lane_lock #(
      .COM_SYM  (COM_SYM),
      .LOCK_CNT (LOCK_CNT),
      .LOSS_CNT (LOSS_CNT)
   ) u_lane_1 (
      .clk_2f      (clk_2f),
      .reset       (reset),
      .lane_byte   (lane_1),
      .valid       (valid_1),
      .stb         (stb_1),
      .align_mode  (align_mode),
      .active_mode (active_mode),
      .clear       (lane_clear),
      .lock        (lock_1_w),
      .loss        (loss_1_w)
   );

   always_comb begin
      state_d    = state_q;
      tmr_d      = '0;
      to_d       = 1'b0;
      resync_d   = resync_q;
      lane_clear = 1'b0;

      if (!enable) begin
         // Disable beats every other transition; resync history is kept.
         state_d    = ST_IDLE;
         lane_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ALIGN;
            end
            ST_ALIGN: begin
               if (lock_0_w && lock_1_w) begin
                  state_d = ST_ACTIVE;
               end else if (tmr_q == TMR_LAST) begin
                  // Restart the whole alignment attempt, stay in ALIGN.
                  to_d       = 1'b1;
                  lane_clear = 1'b1;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (loss_0_w || loss_1_w) begin
                  state_d    = ST_ALIGN;
                  resync_d   = sat_inc(resync_q);
                  lane_clear = 1'b1;
               end
            end
            default: begin
               state_d    = ST_IDLE;
               lane_clear = 1'b1;
            end
         endcase
      end

      // Derived from the next state so it changes on the same edge as state.
      unstr_d = (state_d == ST_ACTIVE);
   end

   always_ff @(posedge clk_2f) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         tmr_q    <= '0;
         to_q     <= 1'b0;
         unstr_q  <= 1'b0;
         resync_q <= '0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         to_q     <= to_d;
         unstr_q  <= unstr_d;
         resync_q <= resync_d;
      end
   end

   assign state         = state_q;
   assign lock_0        = lock_0_w;
   assign lock_1        = lock_1_w;
   assign unstripe_en   = unstr_q;
   assign align_timeout = to_q;
   assign resync_cnt    = resync_q;

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_phy_rx_link_ctrl
// Self-checking bench for phy_rx_link_ctrl: a table of bring-up / broken-
// alignment vectors, hand-written multi-cycle sequences (loss, disable,
// timeout, reset, saturation) and a randomized run against a behavioural model.
// -----------------------------------------------------------------------------
module tb_phy_rx_link_ctrl;

   localparam int LOCK_CNT = 4;
   localparam int LOSS_CNT = 2;
   localparam int TIMEOUT  = 64;
   localparam logic [7:0] BC = 8'hBC;

   logic       clk_2f = 1'b0;
   logic       reset  = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] lane_0 = 8'h00;
   logic       valid_0 = 1'b0;
   logic       stb_0   = 1'b0;
   logic [7:0] lane_1 = 8'h00;
   logic       valid_1 = 1'b0;
   logic       stb_1   = 1'b0;
   logic [1:0] state;
   logic       lock_0, lock_1, unstripe_en, align_timeout;
   logic [3:0] resync_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk_2f = ~clk_2f;

   phy_rx_link_ctrl #(
      .COM_SYM  (BC),
      .LOCK_CNT (LOCK_CNT),
      .LOSS_CNT (LOSS_CNT),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk_2f        (clk_2f),
      .reset         (reset),
      .enable        (enable),
      .lane_0        (lane_0),
      .valid_0       (valid_0),
      .stb_0         (stb_0),
      .lane_1        (lane_1),
      .valid_1       (valid_1),
      .stb_1         (stb_1),
      .state         (state),
      .lock_0        (lock_0),
      .lock_1        (lock_1),
      .unstripe_en   (unstripe_en),
      .align_timeout (align_timeout),
      .resync_cnt    (resync_cnt)
   );

   // ---------------- behavioural reference model ----------------
   // Lane tracking as run lengths; the ALIGN window as an age in cycles.
   int m_state  = 0;      // 0 IDLE, 1 ALIGN, 2 ACTIVE
   int m_age    = 0;      // cycles spent in the current ALIGN window
   int m_resync = 0;
   bit m_to     = 1'b0;
   bit m_lock [2];
   int m_run  [2];
   int m_bad  [2];

   function automatic int kind_of(bit s, bit v, logic [7:0] b);
      if (!s) return 0;          // none
      if (v) return 2;           // data
      if (b == BC) return 1;     // comma
      return 3;                  // bad
   endfunction

   task automatic clear_lanes();
      for (int i = 0; i < 2; i++) begin
         m_lock[i] = 1'b0;
         m_run[i]  = 0;
         m_bad[i]  = 0;
      end
   endtask

   task automatic model_step(input bit rn, input bit en,
                             input logic [7:0] b0, input bit v0, input bit s0,
                             input logic [7:0] b1, input bit v1, input bit s1);
      int k [2];
      k[0] = kind_of(s0, v0, b0);
      k[1] = kind_of(s1, v1, b1);
      m_to = 1'b0;
      if (!rn) begin
         m_state = 0; m_age = 0; m_resync = 0;
         clear_lanes();
      end else if (!en) begin
         m_state = 0; m_age = 0;
         clear_lanes();
      end else if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1) begin
         if (m_lock[0] && m_lock[1]) begin
            m_state = 2; m_age = 0;
         end else if (m_age + 1 == TIMEOUT - 1) begin
            m_to = 1'b1; m_age = 0;
            clear_lanes();
         end else begin
            m_age++;
            for (int i = 0; i < 2; i++) begin
               if (k[i] == 1) begin
                  if (m_run[i] < LOCK_CNT) m_run[i]++;
                  if (m_run[i] == LOCK_CNT) m_lock[i] = 1'b1;
               end else if (k[i] != 0 && !m_lock[i]) begin
                  m_run[i] = 0;
               end
            end
         end
      end else begin
         if (m_bad[0] >= LOSS_CNT || m_bad[1] >= LOSS_CNT) begin
            m_state = 1;
            if (m_resync < 15) m_resync++;
            clear_lanes();
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (k[i] == 3) begin
                  if (m_bad[i] < 15) m_bad[i]++;
               end else if (k[i] != 0) begin
                  m_bad[i] = 0;
               end
            end
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".state"},  32'(state),         32'(m_state));
      chk({tag, ".lock0"},  32'(lock_0),        32'(m_lock[0]));
      chk({tag, ".lock1"},  32'(lock_1),        32'(m_lock[1]));
      chk({tag, ".unstr"},  32'(unstripe_en),   32'(m_state == 2));
      chk({tag, ".tmo"},    32'(align_timeout), 32'(m_to));
      chk({tag, ".resync"}, 32'(resync_cnt),    32'(m_resync));
   endtask

   // Drive on the falling edge, let the DUT sample on the rising edge, step
   // the model for that edge, and compare 1 time unit later.
   task automatic cycle(input bit rn, input bit en,
                        input logic [7:0] b0, input bit v0, input bit s0,
                        input logic [7:0] b1, input bit v1, input bit s1);
      @(negedge clk_2f);
      reset = rn; enable = en;
      lane_0 = b0; valid_0 = v0; stb_0 = s0;
      lane_1 = b1; valid_1 = v1; stb_1 = s1;
      @(posedge clk_2f);
      model_step(rn, en, b0, v0, s0, b1, v1, s1);
      #1;
   endtask

   task automatic idle_cyc(input bit en);
      cycle(1'b1, en, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask
   task automatic comma_both();
      cycle(1'b1, 1'b1, BC, 1'b0, 1'b1, BC, 1'b0, 1'b1);
   endtask
   task automatic bad_l1();
      cycle(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
   endtask
   task automatic data_l1();
      cycle(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit         rn, en;
      logic [7:0] b0; bit v0, s0;
      logic [7:0] b1; bit v1, s1;
      logic [1:0] st; bit l0, l1, un, to;
      logic [3:0] rs;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit rn, bit en,
                               logic [7:0] b0, bit v0, bit s0,
                               logic [7:0] b1, bit v1, bit s1,
                               logic [1:0] st, bit l0, bit l1, bit un, bit to,
                               logic [3:0] rs);
      vec_t v;
      v.rn = rn; v.en = en;
      v.b0 = b0; v.v0 = v0; v.s0 = s0;
      v.b1 = b1; v.v1 = v1; v.s1 = s1;
      v.st = st; v.l0 = l0; v.l1 = l1; v.un = un; v.to = to; v.rs = rs;
      vecs.push_back(v);
   endfunction

   initial begin : main
      int first_to;
      int n_to;

      // Bring-up: reset, enable, four commas on each lane.
      add(0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  2'd0, 0, 0, 0, 0, 4'd0);
      add(1, 1, 8'h00, 0, 0, 8'h00, 0, 0,  2'd1, 0, 0, 0, 0, 4'd0);
      add(1, 1, BC,    0, 1, BC,    0, 1,  2'd1, 0, 0, 0, 0, 4'd0);
      add(1, 1, BC,    0, 1, BC,    0, 1,  2'd1, 0, 0, 0, 0, 4'd0);
      add(1, 1, BC,    0, 1, BC,    0, 1,  2'd1, 0, 0, 0, 0, 4'd0);
      add(1, 1, BC,    0, 1, BC,    0, 1,  2'd1, 1, 1, 0, 0, 4'd0);
      add(1, 1, 8'h00, 0, 0, 8'h00, 0, 0,  2'd2, 1, 1, 1, 0, 4'd0);
      add(1, 1, 8'hA5, 1, 1, 8'h00, 0, 0,  2'd2, 1, 1, 1, 0, 4'd0);
      // Disable, re-enable, then broken alignment on lane 0.
      add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  2'd0, 0, 0, 0, 0, 4'd0);
      add(1, 1, 8'h00, 0, 0, 8'h00, 0, 0,  2'd1, 0, 0, 0, 0, 4'd0);
      add(1, 1, BC,    0, 1, BC,    0, 1,  2'd1, 0, 0, 0, 0, 4'd0);
      add(1, 1, BC,    0, 1, BC,    0, 1,  2'd1, 0, 0, 0, 0, 4'd0);
      add(1, 1, BC,    0, 1, BC,    0, 1,  2'd1, 0, 0, 0, 0, 4'd0);
      add(1, 1, 8'h55, 0, 1, BC,    0, 1,  2'd1, 0, 1, 0, 0, 4'd0);
      add(1, 1, BC,    0, 1, 8'h00, 0, 0,  2'd1, 0, 1, 0, 0, 4'd0);
      add(1, 1, BC,    0, 1, 8'h00, 0, 0,  2'd1, 0, 1, 0, 0, 4'd0);
      add(1, 1, BC,    0, 1, 8'h00, 0, 0,  2'd1, 0, 1, 0, 0, 4'd0);
      add(1, 1, BC,    0, 1, 8'h00, 0, 0,  2'd1, 1, 1, 0, 0, 4'd0);
      add(1, 1, 8'h00, 0, 0, 8'h00, 0, 0,  2'd2, 1, 1, 1, 0, 4'd0);

      foreach (vecs[i]) begin
         cycle(vecs[i].rn, vecs[i].en, vecs[i].b0, vecs[i].v0, vecs[i].s0,
               vecs[i].b1, vecs[i].v1, vecs[i].s1);
         chk($sformatf("vec%0d.state", i),  32'(state),         32'(vecs[i].st));
         chk($sformatf("vec%0d.lock0", i),  32'(lock_0),        32'(vecs[i].l0));
         chk($sformatf("vec%0d.lock1", i),  32'(lock_1),        32'(vecs[i].l1));
         chk($sformatf("vec%0d.unstr", i),  32'(unstripe_en),   32'(vecs[i].un));
         chk($sformatf("vec%0d.tmo", i),    32'(align_timeout), 32'(vecs[i].to));
         chk($sformatf("vec%0d.resync", i), 32'(resync_cnt),    32'(vecs[i].rs));
      end

      // Loss tolerance: bad, data, bad keeps ACTIVE.
      bad_l1();  chk("tol.bad1", 32'(state), 32'd2);
      data_l1(); chk("tol.data", 32'(state), 32'd2);
      bad_l1();  chk("tol.bad2", 32'(state), 32'd2);
      data_l1(); chk("tol.clr",  32'(state), 32'd2);

      // Loss of link: two consecutive bad bytes on lane 1.
      bad_l1();   chk("loss.b1", 32'(state), 32'd2);
      bad_l1();   chk("loss.b2", 32'(state), 32'd2);
      chk("loss.b2.unstr", 32'(unstripe_en), 32'd1);
      idle_cyc(1);
      chk("loss.state",  32'(state),       32'd1);
      chk("loss.unstr",  32'(unstripe_en), 32'd0);
      chk("loss.resync", 32'(resync_cnt),  32'd1);
      chk("loss.lock0",  32'(lock_0),      32'd0);
      chk("loss.lock1",  32'(lock_1),      32'd0);

      // Re-lock, then disable from ACTIVE.
      repeat (4) comma_both();
      idle_cyc(1); chk("relock.state", 32'(state), 32'd2);
      idle_cyc(0);
      chk("dis.state",  32'(state),       32'd0);
      chk("dis.unstr",  32'(unstripe_en), 32'd0);
      chk("dis.resync", 32'(resync_cnt),  32'd1);

      // Timeout: no strobes in ALIGN, single pulse in cycle TIMEOUT-1.
      idle_cyc(1); chk("tmo.enter", 32'(state), 32'd1);
      first_to = -1;
      n_to = 0;
      for (int k = 1; k <= 70; k++) begin
         idle_cyc(1);
         chk($sformatf("tmo.k%0d", k), 32'(align_timeout), 32'(k == TIMEOUT - 1));
         chk($sformatf("tmo.st%0d", k), 32'(state), 32'd1);
         if (align_timeout === 1'b1) begin
            n_to++;
            if (first_to < 0) first_to = k;
         end
      end
      chk("tmo.count", 32'(n_to),     32'd1);
      chk("tmo.first", 32'(first_to), 32'(TIMEOUT - 1));

      // Reset mid-ALIGN with lane 0 locked.
      repeat (4) cycle(1'b1, 1'b1, BC, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      chk("rst.prelock", 32'(lock_0), 32'd1);
      cycle(1'b0, 1'b1, BC, 1'b0, 1'b1, BC, 1'b0, 1'b1);
      chk("rst.state",  32'(state),         32'd0);
      chk("rst.lock0",  32'(lock_0),        32'd0);
      chk("rst.lock1",  32'(lock_1),        32'd0);
      chk("rst.unstr",  32'(unstripe_en),   32'd0);
      chk("rst.tmo",    32'(align_timeout), 32'd0);
      chk("rst.resync", 32'(resync_cnt),    32'd0);

      // Saturation: 16 ACTIVE->ALIGN drops.
      idle_cyc(1);
      for (int i = 1; i <= 16; i++) begin
         repeat (4) comma_both();
         idle_cyc(1);
         chk($sformatf("sat%0d.active", i), 32'(state), 32'd2);
         bad_l1();
         bad_l1();
         idle_cyc(1);
         chk($sformatf("sat%0d.state", i),  32'(state),      32'd1);
         chk($sformatf("sat%0d.resync", i), 32'(resync_cnt), 32'(i > 15 ? 15 : i));
      end
      chk_model("sat.model");

      // Randomized run against the model.
      for (int n = 0; n < 4000; n++) begin
         bit rn, en, v0, s0, v1, s1;
         logic [7:0] b0, b1;
         int r;
         rn = ($urandom_range(0, 499) != 0);
         en = ($urandom_range(0, 199) != 0);
         r = $urandom_range(0, 9);
         b0 = (r < 7) ? BC : (r < 9) ? 8'h55 : 8'h00;
         r = $urandom_range(0, 9);
         b1 = (r < 7) ? BC : (r < 9) ? 8'h55 : 8'h00;
         v0 = ($urandom_range(0, 5) == 0);
         v1 = ($urandom_range(0, 5) == 0);
         s0 = ($urandom_range(0, 1) == 1);
         s1 = ($urandom_range(0, 1) == 1);
         cycle(rn, en, b0, v0, s0, b1, v1, s1);
         chk_model($sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
